// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the comparator sweep driver
//
// Purpose: sweep FSM state encoding, sweep mode codes, default geometry and
//          the bit positions of the {E,G,S} flag triple.
// Contents: state_t, MODE_*, DEF_WIDTH, DEF_LATENCY, FLAG_*, is_onehot3().

package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UNS  = 2'd0;
    localparam logic [1:0] MODE_SGN  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_LATENCY = 3;

    // Bit positions inside the {E,G,S} flag vector
    localparam int FLAG_E = 2;
    localparam int FLAG_G = 1;
    localparam int FLAG_S = 0;

    function automatic logic is_onehot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_expect.sv
// rtl/cmp_expect.sv - combinational reference model of the 6-bit comparator
//
// Purpose: produce the flags a correct comparator returns for (A, B, sel).
// Ports:
//   i_a, i_b  in  WIDTH  operands
//   i_sel     in  1      0 = unsigned compare, 1 = two's-complement compare
//   o_flags   out 3      {E,G,S}, exactly one bit set

module cmp_expect
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [2:0]       o_flags
);

    logic w_eq;
    logic w_gt_uns;
    logic w_gt_sgn;
    logic w_gt;

    assign w_eq     = (i_a == i_b);
    assign w_gt_uns = (i_a > i_b);
    assign w_gt_sgn = ($signed(i_a) > $signed(i_b));
    assign w_gt     = i_sel ? w_gt_sgn : w_gt_uns;

    always_comb begin
        o_flags         = 3'b000;
        o_flags[FLAG_E] = w_eq;
        o_flags[FLAG_G] = w_gt;
        o_flags[FLAG_S] = !w_eq && !w_gt;
    end

endmodule

// File: rtl/cmp_sweep_driver.sv
// rtl/cmp_sweep_driver.sv - exhaustive sweep driver and checker for the comparator
//
// Purpose: drives every (A, B) pair in unsigned and/or signed mode onto the
//          comparator, checks the returned flags LATENCY cycles later, counts
//          failing vectors and captures the first one.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, mode              sweep request pulse and mode (0 uns, 1 sgn, 2/3 both)
//   A_out, B_out, sel_out    operands and signedness to the comparator
//   E_in, G_in, S_in         flags returned by the comparator
//   busy, done, pass         status (busy in DRIVE/DRAIN, done held in DONE)
//   err_count                number of failing vectors in the last sweep
//   fail_a, fail_b, fail_sel first failing vector
//   fail_flags               {E,G,S} it returned

module cmp_sweep_driver
    import cmp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     A_out,
    output logic [WIDTH-1:0]     B_out,
    output logic                 sel_out,
    input  logic                 E_in,
    input  logic                 G_in,
    input  logic                 S_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_sel,
    output logic [2:0]           fail_flags
);

    localparam int            IW       = 2 * WIDTH;
    localparam int            DCW      = $clog2(LATENCY + 1);
    localparam logic [IW-1:0] IDX_LAST = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nxt;
    logic              r_sel;
    logic              w_sel_nxt;
    logic              r_both;
    logic [DCW-1:0]    r_drain_cnt;
    logic              w_accept;
    logic              w_issue;

    // Pipeline carrying each issued vector until its flags come back
    logic              r_pv [LATENCY];
    logic [WIDTH-1:0]  r_pa [LATENCY];
    logic [WIDTH-1:0]  r_pb [LATENCY];
    logic              r_ps [LATENCY];
    logic [2:0]        r_pe [LATENCY];

    logic [2:0]        w_exp;
    logic [2:0]        w_flags;
    logic              w_bad;

    logic [2*WIDTH+1:0] r_err_count;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic               r_fail_sel;
    logic [2:0]         r_fail_flags;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, next vector and issue strobe.
    // w_issue marks every edge that registers a new vector on A_out/B_out;
    // the accepting edge itself issues vector 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = r_sel;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = DRIVE;
                    w_idx_nxt   = '0;
                    w_sel_nxt   = (mode == MODE_SGN);
                end
            end
            DRIVE: begin
                if (r_idx == IDX_LAST) begin
                    if (r_both && !r_sel) begin
                        // unsigned pass finished, signed pass follows with no gap
                        w_issue   = 1'b1;
                        w_idx_nxt = '0;
                        w_sel_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else begin
                    w_issue   = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DCW'(LATENCY - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Vector index, signedness and drain counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_sel       <= 1'b0;
            r_both      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_sel <= w_sel_nxt;
            if (w_accept) begin
                // mode 3 is reserved and behaves as mode 2
                r_both <= mode[1];
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Expected flags are computed on the vector being issued this edge
    cmp_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .i_a     (w_idx_nxt[IW-1:WIDTH]),
        .i_b     (w_idx_nxt[WIDTH-1:0]),
        .i_sel   (w_sel_nxt),
        .o_flags (w_exp)
    );

    // ------------------------------------------------------------------
    // Latency-matching pipeline. Stage LATENCY-1 holds the vector whose
    // flags are on E_in/G_in/S_in at this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_pv[s] <= 1'b0;
                r_pa[s] <= '0;
                r_pb[s] <= '0;
                r_ps[s] <= 1'b0;
                r_pe[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pa[0] <= w_idx_nxt[IW-1:WIDTH];
            r_pb[0] <= w_idx_nxt[WIDTH-1:0];
            r_ps[0] <= w_sel_nxt;
            r_pe[0] <= w_exp;
            for (int s = 1; s < LATENCY; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pa[s] <= r_pa[s-1];
                r_pb[s] <= r_pb[s-1];
                r_ps[s] <= r_ps[s-1];
                r_pe[s] <= r_pe[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checker and failure capture
    // ------------------------------------------------------------------
    assign w_flags = {E_in, G_in, S_in};
    assign w_bad   = r_pv[LATENCY-1] &&
                     (!is_onehot3(w_flags) || (w_flags != r_pe[LATENCY-1]));

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err_count  <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_sel   <= 1'b0;
            r_fail_flags <= '0;
        end else if (w_bad) begin
            r_err_count <= r_err_count + 1'b1;
            // err_count cannot wrap within one sweep, so zero means "no failure yet"
            if (r_err_count == '0) begin
                r_fail_a     <= r_pa[LATENCY-1];
                r_fail_b     <= r_pb[LATENCY-1];
                r_fail_sel   <= r_ps[LATENCY-1];
                r_fail_flags <= w_flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A_out      = r_idx[IW-1:WIDTH];
    assign B_out      = r_idx[WIDTH-1:0];
    assign sel_out    = r_sel;
    assign busy       = (r_state == DRIVE) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign pass       = done && (r_err_count == '0);
    assign err_count  = r_err_count;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_sel   = r_fail_sel;
    assign fail_flags = r_fail_flags;

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// tb/tb_cmp_sweep_driver.sv - self-checking bench for cmp_sweep_driver

module tb_cmp_sweep_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [5:0]  A_out;
    logic [5:0]  B_out;
    logic        sel_out;
    logic        E_in;
    logic        G_in;
    logic        S_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [13:0] err_count;
    logic [5:0]  fail_a;
    logic [5:0]  fail_b;
    logic        fail_sel;
    logic [2:0]  fail_flags;

    // 0 = correct comparator, 1 = G stuck 0 and S = !E, 2 = all flags 1
    int          fault;
    int          n_checks;
    int          n_errors;
    int          cyc;

    cmp_sweep_driver dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .A_out      (A_out),
        .B_out      (B_out),
        .sel_out    (sel_out),
        .E_in       (E_in),
        .G_in       (G_in),
        .S_in       (S_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_sel   (fail_sel),
        .fail_flags (fail_flags)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Registered comparator model: inputs captured at one edge, flags at the next.
    // Signed ordering is done by flipping the sign bit and comparing unsigned.
    logic [5:0] cmp_a;
    logic [5:0] cmp_b;
    logic       cmp_s;
    logic       cmp_e;
    logic       cmp_g;
    logic       cmp_l;
    logic [5:0] key_a;
    logic [5:0] key_b;

    assign key_a = cmp_s ? {~cmp_a[5], cmp_a[4:0]} : cmp_a;
    assign key_b = cmp_s ? {~cmp_b[5], cmp_b[4:0]} : cmp_b;

    always @(posedge clk) begin
        cmp_a <= A_out;
        cmp_b <= B_out;
        cmp_s <= sel_out;
        cmp_e <= (key_a == key_b);
        cmp_g <= (key_a > key_b);
        cmp_l <= (key_a < key_b);
    end

    assign E_in = (fault == 2) ? 1'b1 : cmp_e;
    assign G_in = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : cmp_g;
    assign S_in = (fault == 1) ? ~cmp_e : (fault == 2) ? 1'b1 : cmp_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Returns 1 time unit after the edge that accepts start
    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk);
        #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(inout int c);
        while (!done && c < 20000) begin
            step(1);
            c++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fault    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        step(3);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ab", {A_out, B_out}, 0);
        chk("rst_sel", sel_out, 0);
        chk("rst_fail", {fail_a, fail_b, fail_sel, fail_flags}, 0);

        // Mode 0, correct comparator, with an ignored start mid-DRIVE
        pulse_start(2'd0);
        cyc = 0;
        chk("m0_busy", busy, 1);
        chk("m0_first", {A_out, B_out}, 0);
        step(50);
        cyc = 50;
        chk("m0_idx50", {A_out, B_out}, 50);
        start = 1'b1;
        mode  = 2'd1;
        step(1);
        start = 1'b0;
        mode  = 2'd0;
        cyc   = 51;
        chk("m0_ign_idx", {A_out, B_out}, 51);
        chk("m0_ign_sel", sel_out, 0);
        wait_done(cyc);
        chk("m0_cycles", cyc, 4099);
        chk("m0_err", err_count, 0);
        chk("m0_pass", pass, 1);
        chk("m0_busy_end", busy, 0);

        // Mode 0, G stuck low: every A>B pair fails
        fault = 1;
        pulse_start(2'd0);
        cyc = 0;
        chk("f1_done_clr", done, 0);
        wait_done(cyc);
        chk("f1_cycles", cyc, 4099);
        chk("f1_err", err_count, 2016);
        chk("f1_fail_a", fail_a, 1);
        chk("f1_fail_b", fail_b, 0);
        chk("f1_fail_sel", fail_sel, 0);
        chk("f1_fail_flags", fail_flags, 3'b001);
        chk("f1_pass", pass, 0);

        // Mode 1, all flags high: every vector fails; start in DONE clears results
        fault = 2;
        pulse_start(2'd1);
        cyc = 0;
        chk("f2_err_clr", err_count, 0);
        chk("f2_fail_clr", fail_a, 0);
        chk("f2_sel", sel_out, 1);
        wait_done(cyc);
        chk("f2_cycles", cyc, 4099);
        chk("f2_err", err_count, 4096);
        chk("f2_fail_ab", {fail_a, fail_b}, 0);
        chk("f2_fail_sel", fail_sel, 1);
        chk("f2_fail_flags", fail_flags, 3'b111);
        chk("f2_pass", pass, 0);

        // Mode 2, correct comparator: unsigned then signed, no gap
        fault = 0;
        pulse_start(2'd2);
        cyc = 0;
        chk("m2_err_clr", err_count, 0);
        chk("m2_sel0", sel_out, 0);
        step(4095);
        cyc = 4095;
        chk("m2_last_uns", {sel_out, A_out, B_out}, 13'h0fff);
        step(1);
        cyc = 4096;
        chk("m2_first_sgn", {sel_out, A_out, B_out}, 13'h1000);
        wait_done(cyc);
        chk("m2_cycles", cyc, 8195);
        chk("m2_err", err_count, 0);
        chk("m2_pass", pass, 1);

        // Reset mid-sweep while failures are accumulating
        fault = 1;
        pulse_start(2'd0);
        step(100);
        chk("rs_idx100", {A_out, B_out}, 100);
        chk("rs_err_nz", (err_count != 0), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rs_busy", busy, 0);
        chk("rs_err", err_count, 0);
        chk("rs_a", A_out, 0);
        chk("rs_done", done, 0);
        chk("rs_fail", {fail_a, fail_b, fail_sel, fail_flags}, 0);
        fault = 0;
        pulse_start(2'd0);
        cyc = 0;
        wait_done(cyc);
        chk("rs_cycles", cyc, 4099);
        chk("rs_err_end", err_count, 0);
        chk("rs_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_driver.md
# cmp_sweep_driver

Exhaustive stimulus driver and checker for the registered 6-bit signed/unsigned comparator (`full_circuit`). It drives every (A, B) operand pair in unsigned mode, signed mode, or both, onto the comparator's `A`/`B`/`sel` inputs. It aligns the returned `E`/`G`/`S` flags against its own expected values through a latency-matched pipeline. It counts mismatches and captures the first failing vector. It sits beside the comparator on the same `clk`, as its on-chip self-test counterpart.

## Interface
- `WIDTH`, 6: operand width; sweep covers 2^(2·WIDTH) pairs per mode.
- `LATENCY`, 3: cycles from the edge that registers a vector on `A_out` to the edge that samples its flags.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- `mode` in, 2: 0 = unsigned only, 1 = signed only, 2 = unsigned then signed, 3 = reserved (treated as 2); sampled on the accepted `start`.
- `A_out`, `B_out` out, WIDTH each: operands to the comparator.
- `sel_out` out, 1: 0 = unsigned, 1 = signed.
- `E_in`, `G_in`, `S_in` in, 1 each: comparator result flags.
- `busy` out, 1: high in DRIVE and DRAIN.
- `done` out, 1: high in DONE; held until the next accepted `start` or `rst`.
- `pass` out, 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` out, 2·WIDTH+2: number of failing vectors.
- `fail_a`, `fail_b` out, WIDTH each; `fail_sel` out, 1; `fail_flags` out, 3 ({E,G,S}): first failing vector and the flags it returned.

## Operation
- States:
  - IDLE → DRIVE on `start`.
  - DRIVE → DRAIN after the last vector is issued.
  - DRAIN → DONE after LATENCY cycles.
  - DONE → DRIVE on `start`.
- Vector index `i`, 2·WIDTH bits:
  - `A_out` = i[2W-1:W], `B_out` = i[W-1:0].
  - `i` increments every DRIVE cycle starting at 0 and wraps to 0 at the end of each mode pass.
  - In mode 2, the unsigned pass (`sel_out`=0) is followed by the signed pass (`sel_out`=1) with no gap.
- Expected flags per vector:
  - E = (A==B).
  - G = A>B: unsigned, or two's-complement when `sel_out`=1.
  - S = !E && !G.
- A vector fails if the returned {E,G,S} is not one-hot or differs from the expected flags.
- Failure reporting:
  - `err_count` increments by 1 per failing vector.
  - `fail_*` latch on the first failure only.
- An accepted `start` clears `err_count`, `fail_*`, `pass` and `done`.
- `start` while `busy` is ignored.

## Timing
- Reset values: `A_out`=`B_out`=0, `sel_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, all `fail_*`=0, state IDLE, pipeline valids cleared.
- Vector alignment:
  - A vector registered on `A_out`/`B_out`/`sel_out` at edge k is captured by the comparator at edge k+1.
  - Its flags update at edge k+2 and are sampled and checked at edge k+3 (= k+LATENCY).
  - A LATENCY-deep shift register carries {valid, A, B, sel, expected}.
- Sweep length:
  - One new vector per cycle.
  - Mode 0/1: 4096 DRIVE cycles; mode 2: 8192.
  - DRAIN holds outputs at the last vector until all valids retire.
  - `done` rises LATENCY cycles after the last DRIVE cycle.
- `rst` asserted in any state, including mid-sweep: next cycle every output is at its reset value and the pipeline is flushed. No partial count survives.
- Failure on the final vector: counted before `done` rises; `pass` reflects it in the same cycle `done` rises.
- The comparator's gate delays (~60 units worst path) must settle within one `clk` period. Bench clock period is 100 units.

## Structure
- Package `cmp_pkg`:
  - state enum (IDLE, DRIVE, DRAIN, DONE);
  - mode constants (MODE_UNS=0, MODE_SGN=1, MODE_BOTH=2);
  - default WIDTH and LATENCY;
  - flag-index constants (E=2, G=1, S=0).
- Sub-module `cmp_expect`: purely combinational reference model, (A, B, sel) → expected {E,G,S}. It is instantiated once at the issue stage.

## Test plan
- Mode 0 against a correct `full_circuit`: `start` → `done` 4099 cycles after `start` is accepted; `err_count`=0, `pass`=1.
- Mode 2 against a correct `full_circuit`: `done` after 8192+3 cycles; `err_count`=0, `pass`=1; `sel_out` switches 0→1 at vector 4096.
- Mode 0 with `G_in` tied 0 and `S_in` = !`E_in`: `err_count`=2016; `fail_a`=1, `fail_b`=0, `fail_sel`=0, `fail_flags`=3'b001; `pass`=0.
- Mode 1 with `E_in`=`G_in`=`S_in`=1: `err_count`=4096; `fail_a`=0, `fail_b`=0, `fail_flags`=3'b111.
- Mode 0, `rst` at DRIVE cycle 100: next cycle `busy`=0, `err_count`=0, `A_out`=0; a fresh `start` completes with `pass`=1.
- `start` pulsed mid-DRIVE is ignored: `i` is unaffected and `done` timing is unchanged. `start` in DONE clears `done` and `err_count` and restarts from `i`=0.
